// File: rtl/cdu_req_sequencer_if.sv
// Request/response/CDU signal bundle for cdu_req_sequencer.
//   req_*     : requester -> sequencer (valid/ready, cmd, data, token)
//   cdu_*     : sequencer <-> compression/decompression unit
//   rsp_*     : sequencer -> requester (valid/ready, code, results, timeout flag)
//   busy, fifo_count : status
// slave modport is the sequencer view, master modport the environment view.
interface cdu_req_sequencer_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_cmd;
   logic [79:0]      req_data;
   logic [7:0]       req_comp;

   logic [1:0]       cdu_command;
   logic [79:0]      cdu_data_in;
   logic [7:0]       cdu_compressed_in;
   logic [7:0]       cdu_compressed_out;
   logic [79:0]      cdu_decompressed_out;
   logic [1:0]       cdu_response;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_code;
   logic [7:0]       rsp_comp;
   logic [79:0]      rsp_data;
   logic             rsp_timeout;

   logic             busy;
   logic [CNT_W-1:0] fifo_count;

   modport slave (
      input  req_valid, req_cmd, req_data, req_comp,
      output req_ready,
      output cdu_command, cdu_data_in, cdu_compressed_in,
      input  cdu_compressed_out, cdu_decompressed_out, cdu_response,
      output rsp_valid, rsp_code, rsp_comp, rsp_data, rsp_timeout,
      input  rsp_ready,
      output busy, fifo_count
   );

   modport master (
      output req_valid, req_cmd, req_data, req_comp,
      input  req_ready,
      input  cdu_command, cdu_data_in, cdu_compressed_in,
      output cdu_compressed_out, cdu_decompressed_out, cdu_response,
      input  rsp_valid, rsp_code, rsp_comp, rsp_data, rsp_timeout,
      output rsp_ready,
      input  busy, fifo_count
   );
endinterface

// File: rtl/cdu_req_sequencer.sv
// Request front-end for the CDU: buffers requests in a DEPTH-entry FIFO,
// issues them one at a time as single-cycle CDU commands, waits for the CDU
// response (bounded by TIMEOUT cycles) and returns the result over rsp_*.
// Ports: clk, reset (async, active-low), bus (cdu_req_sequencer_if.slave).
module cdu_req_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   cdu_req_sequencer_if.slave bus
);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned TMO_W  = 8;
   localparam int unsigned DATA_W = 80;
   localparam int unsigned COMP_W = 8;

   localparam logic [1:0] CMD_NOP    = 2'b00;
   localparam logic [1:0] CMD_COMP   = 2'b01;
   localparam logic [1:0] CMD_DECOMP = 2'b10;
   localparam logic [1:0] RSP_ERR    = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_HOLD} state_e;

   typedef struct packed {
      logic [1:0]        cmd;
      logic [DATA_W-1:0] data;
      logic [COMP_W-1:0] comp;
   } req_t;

   req_t              mem_q [DEPTH];
   req_t              wr_entry_c, head_c;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_e            state_q, state_d;
   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [1:0]        cdu_cmd_q, cdu_cmd_d;
   logic [DATA_W-1:0] cdu_data_q, cdu_data_d;
   logic [COMP_W-1:0] cdu_comp_q, cdu_comp_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [1:0]        rsp_code_q, rsp_code_d;
   logic [COMP_W-1:0] rsp_comp_q, rsp_comp_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_tmo_q, rsp_tmo_d;
   logic              busy_q, busy_d;
   logic              req_ready_c, push_c, pop_c;

   // Ready comes straight from the registered count, so a pop at full never frees a slot early.
   assign req_ready_c = (count_q != CNT_W'(DEPTH));
   assign push_c      = bus.req_valid && req_ready_c;
   assign head_c      = mem_q[rd_ptr_q];
   assign wr_entry_c  = '{cmd: bus.req_cmd, data: bus.req_data, comp: bus.req_comp};

   // Next-state, FIFO bookkeeping and output computation.
   always_comb begin
      state_d     = state_q;
      tmo_cnt_d   = tmo_cnt_q;
      cdu_cmd_d   = cdu_cmd_q;
      cdu_data_d  = cdu_data_q;
      cdu_comp_d  = cdu_comp_q;
      rsp_valid_d = rsp_valid_q;
      rsp_code_d  = rsp_code_q;
      rsp_comp_d  = rsp_comp_q;
      rsp_data_d  = rsp_data_q;
      rsp_tmo_d   = rsp_tmo_q;
      pop_c       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               pop_c = 1'b1;
               if (head_c.cmd == CMD_COMP || head_c.cmd == CMD_DECOMP) begin
                  cdu_cmd_d  = head_c.cmd;
                  cdu_data_d = head_c.data;
                  cdu_comp_d = head_c.comp;
                  state_d    = ST_ISSUE;
               end else begin
                  // NOP/invalid: answered locally, CDU untouched; valid follows one cycle later in HOLD.
                  rsp_code_d = RSP_ERR;
                  rsp_tmo_d  = 1'b0;
                  state_d    = ST_HOLD;
               end
            end
         end
         ST_ISSUE: begin
            cdu_cmd_d = CMD_NOP;
            tmo_cnt_d = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            // A response in the expiry cycle takes priority over the timeout.
            if (bus.cdu_response != 2'b00) begin
               rsp_code_d  = bus.cdu_response;
               rsp_comp_d  = bus.cdu_compressed_out;
               rsp_data_d  = bus.cdu_decompressed_out;
               rsp_tmo_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT)) begin
               rsp_code_d  = RSP_ERR;
               rsp_comp_d  = '0;
               rsp_data_d  = '0;
               rsp_tmo_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         ST_HOLD: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pointers wrap naturally since DEPTH is a power of two.
      wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_c && !pop_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
         count_d = count_q - CNT_W'(1);
      end

      busy_d = (state_d != ST_IDLE);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tmo_cnt_q   <= '0;
         cdu_cmd_q   <= '0;
         cdu_data_q  <= '0;
         cdu_comp_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_code_q  <= '0;
         rsp_comp_q  <= '0;
         rsp_data_q  <= '0;
         rsp_tmo_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tmo_cnt_q   <= tmo_cnt_d;
         cdu_cmd_q   <= cdu_cmd_d;
         cdu_data_q  <= cdu_data_d;
         cdu_comp_q  <= cdu_comp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_code_q  <= rsp_code_d;
         rsp_comp_q  <= rsp_comp_d;
         rsp_data_q  <= rsp_data_d;
         rsp_tmo_q   <= rsp_tmo_d;
         busy_q      <= busy_d;
      end
   end

   // FIFO storage; contents are don't-care while the count is zero.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= wr_entry_c;
      end
   end

   assign bus.req_ready         = req_ready_c;
   assign bus.cdu_command       = cdu_cmd_q;
   assign bus.cdu_data_in       = cdu_data_q;
   assign bus.cdu_compressed_in = cdu_comp_q;
   assign bus.rsp_valid         = rsp_valid_q;
   assign bus.rsp_code          = rsp_code_q;
   assign bus.rsp_comp          = rsp_comp_q;
   assign bus.rsp_data          = rsp_data_q;
   assign bus.rsp_timeout       = rsp_tmo_q;
   assign bus.busy              = busy_q;
   assign bus.fifo_count        = count_q;
endmodule

// File: tb/tb_cdu_req_sequencer.sv
// Scoreboard bench for cdu_req_sequencer: expected commands and responses are
// queued on request acceptance; a monitor pops and compares them whenever the
// DUT issues a CDU command or completes a response handshake.
module tb_cdu_req_sequencer;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 16;

   typedef struct {
      logic [1:0]  code;
      logic [7:0]  comp;
      logic [79:0] data;
      logic        tmo;
      logic        chk_pl;
   } exp_rsp_t;

   typedef struct {
      logic [1:0]  cmd;
      logic [79:0] data;
      logic [7:0]  comp;
   } exp_cmd_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   exp_rsp_t rsp_q[$];
   exp_cmd_t cmd_q[$];

   // CDU model knobs
   logic        mdl_en;
   int          mdl_lat;
   logic [1:0]  mdl_rsp;
   logic [7:0]  mdl_comp;
   logic [79:0] mdl_data;

   cdu_req_sequencer_if #(.DEPTH(DEPTH)) bus ();

   cdu_req_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: expected event did not occur as required (cycle %0d)", name, cyc);
   endtask

   function automatic exp_rsp_t mk(input logic [1:0] code, input logic [7:0] comp,
                                    input logic [79:0] data, input logic tmo, input logic chk_pl);
      exp_rsp_t e;
      e.code = code; e.comp = comp; e.data = data; e.tmo = tmo; e.chk_pl = chk_pl;
      return e;
   endfunction

   // Call at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic push(input logic [1:0] c, input logic [79:0] d, input logic [7:0] p, input exp_rsp_t e);
      bit ok = 1'b0;
      exp_cmd_t ec;
      bus.req_valid = 1'b1;
      bus.req_cmd   = c;
      bus.req_data  = d;
      bus.req_comp  = p;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.req_ready;
         @(posedge clk);
         if (!ok) @(negedge clk);
      end
      if (!ok) begin
         fail("push_accept");
      end else begin
         if (c == 2'b01 || c == 2'b10) begin
            ec.cmd = c; ec.data = d; ec.comp = p;
            cmd_q.push_back(ec);
         end
         rsp_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic wait_for(input string name, input bit sel_rsp, input int budget, output int t);
      bit hit = 1'b0;
      t = 0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk); #1;
         if (sel_rsp ? bus.rsp_valid : bus.busy) begin
            hit = 1'b1;
            t   = cyc;
         end
      end
      if (!hit) fail(name);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (rsp_q.size() != 0 || cmd_q.size() != 0); i++) begin
         @(negedge clk); #1;
      end
      if (rsp_q.size() != 0 || cmd_q.size() != 0) begin
         fail("drain");
         rsp_q.delete();
         cmd_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic sample();
      @(negedge clk); #1;
   endtask

   // CDU model: answers each command after mdl_lat falling edges, for one cycle.
   initial begin
      bus.cdu_response         = 2'b00;
      bus.cdu_compressed_out   = 8'h00;
      bus.cdu_decompressed_out = 80'h0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && bus.cdu_command != 2'b00 && mdl_en) begin
            repeat (mdl_lat) @(negedge clk);
            bus.cdu_response         = mdl_rsp;
            bus.cdu_compressed_out   = mdl_comp;
            bus.cdu_decompressed_out = mdl_data;
            @(negedge clk);
            bus.cdu_response         = 2'b00;
         end
      end
   end

   // Monitor: compares issued commands and completed responses against the queues.
   initial begin
      logic [1:0] prev_cmd = 2'b00;
      exp_cmd_t   ec;
      exp_rsp_t   er;
      forever begin
         @(negedge clk); #1;
         if (reset === 1'b1) begin
            if (bus.cdu_command != 2'b00) begin
               check("cmd_gap", 80'(prev_cmd), 80'(0));
               if (cmd_q.size() == 0) begin
                  fail("cmd_unexpected");
               end else begin
                  ec = cmd_q.pop_front();
                  check("cmd_code", 80'(bus.cdu_command), 80'(ec.cmd));
                  check("cmd_data", bus.cdu_data_in, ec.data);
                  check("cmd_comp", 80'(bus.cdu_compressed_in), 80'(ec.comp));
               end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (rsp_q.size() == 0) begin
                  fail("rsp_unexpected");
               end else begin
                  er = rsp_q.pop_front();
                  check("rsp_code", 80'(bus.rsp_code), 80'(er.code));
                  check("rsp_timeout", 80'(bus.rsp_timeout), 80'(er.tmo));
                  if (er.chk_pl) begin
                     check("rsp_comp", 80'(bus.rsp_comp), 80'(er.comp));
                     check("rsp_data", bus.rsp_data, er.data);
                  end
               end
            end
            prev_cmd = bus.cdu_command;
         end else begin
            prev_cmd = 2'b00;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1;
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_cmd   = 2'b00;
      bus.req_data  = 80'h0;
      bus.req_comp  = 8'h00;
      bus.rsp_ready = 1'b0;
      mdl_en = 1'b0; mdl_lat = 2; mdl_rsp = 2'b01; mdl_comp = 8'h00; mdl_data = 80'h0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_cdu_command", 80'(bus.cdu_command), 80'(0));
      check("rst_rsp_valid", 80'(bus.rsp_valid), 80'(0));
      check("rst_req_ready", 80'(bus.req_ready), 80'(1));
      check("rst_fifo_count", 80'(bus.fifo_count), 80'(0));
      check("rst_busy", 80'(bus.busy), 80'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Compress, CDU answers two cycles after the command
      mdl_en = 1'b1; mdl_lat = 2; mdl_rsp = 2'b01; mdl_comp = 8'h5A; mdl_data = 80'h0;
      bus.rsp_ready = 1'b1;
      push(2'b01, 80'h0123_4567_89AB_CDEF_0011, 8'h00, mk(2'b01, 8'h5A, 80'h0, 1'b0, 1'b1));
      bus.req_valid = 1'b0;
      sample();
      check("comp_cmd_cycle", 80'(bus.cdu_command), 80'(2'b01));
      check("comp_busy", 80'(bus.busy), 80'(1));
      sample();
      check("comp_cmd_single", 80'(bus.cdu_command), 80'(0));
      check("comp_rsp_early0", 80'(bus.rsp_valid), 80'(0));
      sample();
      check("comp_rsp_early1", 80'(bus.rsp_valid), 80'(0));
      sample();
      check("comp_rsp_valid", 80'(bus.rsp_valid), 80'(1));
      drain(50);

      // Decompress miss
      mdl_lat = 1; mdl_rsp = 2'b10; mdl_comp = 8'h00; mdl_data = 80'h0;
      push(2'b10, 80'h0, 8'h33, mk(2'b10, 8'h00, 80'h0, 1'b0, 1'b1));
      bus.req_valid = 1'b0;
      drain(50);

      // Timeout, then a late response during HOLD must be ignored
      mdl_lat = 25; mdl_rsp = 2'b01; mdl_comp = 8'h77; mdl_data = 80'hFF;
      bus.rsp_ready = 1'b0;
      push(2'b01, 80'hABCD, 8'h11, mk(2'b11, 8'h00, 80'h0, 1'b1, 1'b1));
      bus.req_valid = 1'b0;
      wait_for("tmo_pop", 1'b0, 20, t0);
      wait_for("tmo_rsp", 1'b1, 40, t1);
      check("tmo_latency", 80'(t1 - t0), 80'(TIMEOUT + 2));
      check("tmo_code", 80'(bus.rsp_code), 80'(2'b11));
      check("tmo_flag", 80'(bus.rsp_timeout), 80'(1));
      repeat (9) @(negedge clk);
      #1;
      check("late_code", 80'(bus.rsp_code), 80'(2'b11));
      check("late_comp", 80'(bus.rsp_comp), 80'(0));
      check("late_data", bus.rsp_data, 80'h0);
      check("late_valid", 80'(bus.rsp_valid), 80'(1));
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      drain(50);

      // Invalid command 11: no CDU command, result one edge after the pop
      push(2'b11, 80'h5555, 8'h55, mk(2'b11, 8'h00, 80'h0, 1'b0, 1'b0));
      bus.req_valid = 1'b0;
      wait_for("inv11_pop", 1'b0, 20, t0);
      wait_for("inv11_rsp", 1'b1, 20, t1);
      check("inv11_latency", 80'(t1 - t0), 80'(1));
      check("inv11_cdu_data_held", bus.cdu_data_in, 80'hABCD);
      drain(50);

      // NOP, left pending in HOLD so the next phase starts with the FSM occupied
      bus.rsp_ready = 1'b0;
      push(2'b00, 80'h0, 8'h00, mk(2'b11, 8'h00, 80'h0, 1'b0, 1'b0));
      bus.req_valid = 1'b0;
      wait_for("nop_pop", 1'b0, 20, t0);
      wait_for("nop_rsp", 1'b1, 20, t1);
      check("nop_latency", 80'(t1 - t0), 80'(1));
      check("nop_code", 80'(bus.rsp_code), 80'(2'b11));

      // FIFO full and backpressure
      mdl_en = 1'b1; mdl_lat = 1; mdl_rsp = 2'b01; mdl_comp = 8'h5A; mdl_data = 80'h0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         push((i % 2) ? 2'b10 : 2'b01, 80'h1000 + 80'(i), 8'h20 + 8'(i),
              mk(2'b01, 8'h5A, 80'h0, 1'b0, 1'b1));
         if (i == 2) begin
            check("full_count3", 80'(bus.fifo_count), 80'(3));
            check("full_ready3", 80'(bus.req_ready), 80'(1));
         end
      end
      #1;
      check("full_count4", 80'(bus.fifo_count), 80'(4));
      check("full_ready4", 80'(bus.req_ready), 80'(0));
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_cmd   = 2'b01;
      bus.req_data  = 80'h1004;
      bus.req_comp  = 8'h24;
      repeat (3) sample();
      check("full_stalled", 80'(bus.fifo_count), 80'(4));
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      push(2'b01, 80'h1004, 8'h24, mk(2'b01, 8'h5A, 80'h0, 1'b0, 1'b1));
      bus.req_valid = 1'b0;
      drain(300);

      // Reset while in WAIT with two entries queued
      mdl_en = 1'b0;
      push(2'b01, 80'hDEAD, 8'h01, mk(2'b01, 8'h00, 80'h0, 1'b0, 1'b0));
      push(2'b10, 80'hBEEF, 8'h02, mk(2'b01, 8'h00, 80'h0, 1'b0, 1'b0));
      push(2'b01, 80'hCAFE, 8'h03, mk(2'b01, 8'h00, 80'h0, 1'b0, 1'b0));
      bus.req_valid = 1'b0;
      repeat (2) sample();
      check("rstw_count", 80'(bus.fifo_count), 80'(2));
      check("rstw_busy", 80'(bus.busy), 80'(1));
      #1;
      reset = 1'b0;
      #1;
      check("rstw_cdu_data", bus.cdu_data_in, 80'h0);
      check("rstw_cdu_cmd", 80'(bus.cdu_command), 80'(0));
      check("rstw_count0", 80'(bus.fifo_count), 80'(0));
      check("rstw_busy0", 80'(bus.busy), 80'(0));
      check("rstw_ready", 80'(bus.req_ready), 80'(1));
      cmd_q.delete();
      rsp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      repeat (10) sample();
      check("post_rst_count", 80'(bus.fifo_count), 80'(0));
      check("post_rst_valid", 80'(bus.rsp_valid), 80'(0));
      check("post_rst_cdu_data", bus.cdu_data_in, 80'h0);
      check("post_rst_busy", 80'(bus.busy), 80'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/cdu_req_sequencer.md
# cdu_req_sequencer

Request front-end that sits directly upstream of the compression/decompression unit (CDU). It buffers compress/decompress requests from the system in a small FIFO and issues them to the CDU one at a time as single-cycle commands. It waits for the CDU response, with a timeout, and returns the result to the requester over a valid/ready channel.

## Interface
- DEPTH, 4: request FIFO depth; power of two, ≥2
- TIMEOUT, 16: WAIT cycles without a CDU response before a timeout is declared; 1..255

- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low
- req_valid  in  1  request offered
- req_ready  out  1  request FIFO not full
- req_cmd  in  2  00 NOP, 01 compress, 10 decompress, 11 invalid
- req_data  in  80  uncompressed data (compress)
- req_comp  in  8  compressed token (decompress)
- cdu_command  out  2  command to CDU
- cdu_data_in  out  80  data to CDU
- cdu_compressed_in  out  8  token to CDU
- cdu_compressed_out  in  8  CDU compress result
- cdu_decompressed_out  in  80  CDU decompress result
- cdu_response  in  2  00 none, 01 success, 10 not found, 11 error
- rsp_valid  out  1  result available
- rsp_ready  in  1  requester accepts result
- rsp_code  out  2  final response code
- rsp_comp  out  8  captured cdu_compressed_out
- rsp_data  out  80  captured cdu_decompressed_out
- rsp_timeout  out  1  result produced by timeout
- busy  out  1  FSM not in IDLE
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset, asynchronous while low:
  - FIFO is emptied and FSM goes to IDLE.
  - All registered outputs are 0, so cdu_command=00 immediately.
  - req_ready reads 1 (count 0).
  - An in-flight CDU transaction is abandoned and no result is produced.
- FIFO push: on req_valid & req_ready. req_ready = (fifo_count != DEPTH), derived from the registered count. At full, a same-cycle pop does not enable a push.
- FIFO pop: only in IDLE when fifo_count>0. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE:
    - If the FIFO head cmd is 01 or 10: pop, load cdu_command, cdu_data_in and cdu_compressed_in from the head, then go to ISSUE.
    - If the head cmd is 00 or 11: pop, do not touch the CDU, set rsp_code=11 and rsp_timeout=0, then go to HOLD.
  - ISSUE: one cycle only. Clear cdu_command to 00, clear the timeout counter, go to WAIT.
  - WAIT:
    - Sample cdu_response every cycle. If it is nonzero, capture rsp_code, rsp_comp and rsp_data from the CDU outputs, set rsp_timeout=0, go to HOLD.
    - Otherwise increment the counter. When the counter reaches TIMEOUT, set rsp_code=11, rsp_timeout=1, rsp_comp=0, rsp_data=0, and go to HOLD.
    - If a response arrives in the same cycle the timeout expires, the response wins.
  - HOLD: rsp_valid=1 and result registers are held stable. On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE.
- cdu_data_in and cdu_compressed_in stay at their last issued values until the next issue. Only cdu_command returns to 00.
- Responses arriving outside WAIT are ignored.
- Exactly one CDU command is outstanding at any time.

## Timing
- Request accepted at edge N into an empty FIFO with the FSM in IDLE:
  - Pop at edge N+1; cdu_command is valid during cycle N+1→N+2.
  - FSM is in WAIT from edge N+2.
- CDU response seen at edge M (in WAIT): rsp_valid=1 from edge M.
- Minimum request-to-result latency is 3 cycles plus CDU latency.
- Timeout: rsp_valid rises TIMEOUT+2 edges after the pop edge.
- Invalid or NOP request: rsp_valid rises 1 edge after the pop.
- Back-to-back requests: after the rsp handshake edge H, the next pop happens at H+1 (FSM passes through IDLE). cdu_command is therefore never 01/10 in two consecutive cycles.
- busy=1 from the pop edge until the handshake edge.

## Test plan
- Compress:
  - Stimulus: req_cmd=01, req_data=80'h0123_4567_89AB_CDEF_0011; CDU returns response=01, compressed_out=8'h5A two cycles after the command.
  - Required: exactly one cycle of cdu_command=01 with that data; rsp_code=01, rsp_comp=8'h5A, rsp_timeout=0.
- Decompress miss:
  - Stimulus: req_cmd=10, req_comp=8'h33; CDU returns response=10.
  - Required: rsp_code=10 and rsp_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=16; CDU never responds.
  - Required: rsp_valid rises 18 edges after the pop with rsp_code=11 and rsp_timeout=1.
  - Follow-up: a late response=01 arriving while in HOLD is ignored.
- FIFO full and backpressure:
  - Stimulus: push 5 requests with rsp_ready=0.
  - Required: req_ready drops when fifo_count=4 and the 5th request is stalled. After releasing rsp_ready, all accepted requests complete in order, each with one command cycle and no command gaps shorter than 1 idle cycle.
- Invalid command: req_cmd=11 → the CDU sees no command, rsp_code=11 one cycle after the pop. req_cmd=00 behaves the same.
- Reset mid-WAIT:
  - Stimulus: with 2 entries queued, assert reset low during WAIT.
  - Required: outputs zero immediately; after release fifo_count=0, rsp_valid=0, and no command is issued.
